// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: one register stage per prefix level,
// with a valid/ready chain that lets bubbles collapse anywhere in the pipe.
module ks_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int L     = LOG2W + 2;

  logic [L-1:0] v_q, v_d;
  logic [L-1:0] rdy;

  // Unrolled ready chain: stage k can load unless it and everything after it is full and stalled.
  for (genvar k = 0; k < L; k++) begin : g_rdy
    assign rdy[k] = out_ready || !(&v_q[L-1:k]);
  end

  assign in_ready  = rdy[0] && !rst;
  assign out_valid = v_q[L-1];
  assign v_d       = {v_q[L-2:0], in_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      for (int unsigned k = 0; k < L; k++) begin
        if (rdy[k]) v_q[k] <= v_d[k];
      end
    end
  end

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g_q   [LOG2W+1];
  logic [WIDTH-1:0] p_q   [LOG2W+1];
  logic [WIDTH-1:0] x_q   [LOG2W+1];
  logic             c_q   [LOG2W+1];
  logic             am_q  [LOG2W+1];
  logic             bm_q  [LOG2W+1];
  logic [TAG_W-1:0] tag_q [LOG2W+1];
  logic [WIDTH-1:0] g_d   [1:LOG2W];
  logic [WIDTH-1:0] p_d   [1:LOG2W];

  assign bx = in_sub ? ~in_b : in_b;

  // Grey cells fold the carry-in into bits whose group already reaches bit 0 and
  // zero their propagate; the output stage finishes any bit still missing it.
  always_comb begin
    int unsigned span;
    span = 0;
    for (int unsigned k = 1; k <= LOG2W; k++) begin
      span   = 1 << (k - 1);
      g_d[k] = g_q[k-1];
      p_d[k] = p_q[k-1];
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i >= span) begin
          g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-span]);
          p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-span];
        end else begin
          g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & c_q[k-1]);
          p_d[k][i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy[0]) begin
      g_q[0]   <= in_a & bx;
      p_q[0]   <= in_a | bx;
      x_q[0]   <= in_a ^ bx;
      c_q[0]   <= in_sub | in_cin;
      am_q[0]  <= in_a[WIDTH-1];
      bm_q[0]  <= bx[WIDTH-1];
      tag_q[0] <= in_tag;
    end
    for (int unsigned k = 1; k <= LOG2W; k++) begin
      if (rdy[k]) begin
        g_q[k]   <= g_d[k];
        p_q[k]   <= p_d[k];
        x_q[k]   <= x_q[k-1];
        c_q[k]   <= c_q[k-1];
        am_q[k]  <= am_q[k-1];
        bm_q[k]  <= bm_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  logic [WIDTH-1:0] carry, sum_d;

  assign carry = g_q[LOG2W] | (p_q[LOG2W] & {WIDTH{c_q[LOG2W]}});
  assign sum_d = x_q[LOG2W] ^ {carry[WIDTH-2:0], c_q[LOG2W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
      out_tag  <= '0;
    end else if (rdy[L-1]) begin
      out_sum  <= sum_d;
      out_cout <= carry[WIDTH-1];
      out_ovf  <= (am_q[LOG2W] == bm_q[LOG2W]) && (sum_d[WIDTH-1] != am_q[LOG2W]);
      out_zero <= ~|sum_d;
      out_tag  <= tag_q[LOG2W];
    end
  end

endmodule

// File: doc/ks_adder_pipe.md
# ks_adder_pipe

Parametrised, fully pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on input and output. It generalises the 8-bit combinational Kogge-Stone adder to any power-of-two width. It registers every prefix level and adds a subtract mode, overflow/zero flags and a pass-through tag. It sits between operand producers (ALU issue, accumulators) and consumers that may apply backpressure.

## Interface
- `WIDTH`, 32: operand width; power of two, 8..64.
- `TAG_W`, 4: width of the opaque tag carried alongside each operation; minimum 1.
- Derived: `LOG2W` = log2(`WIDTH`); `L` = `LOG2W` + 2 (pipeline depth and latency).

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand beat present.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_a` in `WIDTH`: operand A.
- `in_b` in `WIDTH`: operand B.
- `in_cin` in 1: carry-in; ignored when `in_sub`=1.
- `in_sub` in 1: 1 = A - B, 0 = A + B + cin.
- `in_tag` in `TAG_W`: returned unchanged with the result.
- `out_valid` out 1: result beat present.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out `WIDTH`: result.
- `out_cout` out 1: carry out of MSB; for subtract, 1 = no borrow.
- `out_ovf` out 1: signed two's-complement overflow.
- `out_zero` out 1: `out_sum` == 0.
- `out_tag` out `TAG_W`: tag of this result.

## Operation
- Effective operand Bx = `in_sub` ? ~`in_b` : `in_b`. Effective carry-in c = `in_sub` ? 1 : `in_cin`.
- Stage 0 registers the per-bit generate (a&bx), propagate-or (a|bx) and xor (a^bx) terms, plus c, the A/Bx MSBs and the tag.
- Stages 1..`LOG2W` each register one prefix level at span 2^(k-1).
  - Bit i combines with bit i-span.
  - Bits below span fold in c, treated as generate at position -1, using a grey cell.
  - Bits below span pass through unchanged once they are already complete.
- Stage `L`-1 registers the outputs:
  - sum[i] = xor[i] ^ carry[i-1], with carry[-1] = c.
  - cout = carry[`WIDTH`-1].
  - ovf = (a_msb == bx_msb) && (sum_msb != a_msb).
  - zero = ~|sum.
  - The tag passes through unchanged.
- Each stage k has a valid bit v_k.
  - ready_k = !v_k || ready_(k+1), where ready_L = `out_ready`.
  - Stage k loads when ready_k; its valid becomes v_(k-1), with v_-1 = `in_valid`.
  - Bubbles collapse, so a hole anywhere lets upstream advance.
- `in_ready` = ready_0. It is forced 0 while `rst` is high.
- `out_valid` = v_(L-1).
- Capacity is `L` beats. Results leave strictly in acceptance order. No beat is dropped or duplicated.
- Data registers of stages with valid 0 may hold stale data. `out_*` data is only meaningful when `out_valid`=1.

## Timing
- Reset (async assert, sync-safe deassert):
  - all v_k = 0
  - `out_valid` = 0
  - `out_sum` = 0, `out_cout` = 0, `out_ovf` = 0, `out_zero` = 0, `out_tag` = 0
  - `in_ready` = 1 from the first cycle after `rst` falls.
- Latency: a beat accepted at edge t (`in_valid`&&`in_ready`) presents `out_valid`=1 after edge t+`L`-1, provided there is no stall. Example: `WIDTH`=8 gives `L`=5.
- Throughput: 1 beat/cycle whenever `out_ready`=1.
- Stall: while `out_valid`&&!`out_ready`, the output stage holds all its outputs stable; upstream stages fill. `in_ready` falls combinationally once all `L` stages are valid and `out_ready`=0.
- Simultaneous events: output pop and input push in the same cycle with the pipe full is legal, because the ready chain propagates in the same cycle. Occupancy stays at `L`.
- Reset mid-operation: all in-flight beats are discarded; no `out_valid` until new beats arrive.
- Combinational paths: `out_ready` -> `in_ready` through the ready chain. There is no combinational path from `in_*` to `out_*`.

## Test plan
- Add-with-carry wrap, `WIDTH`=8: A=0xFF, B=0x01, cin=0, sub=0 -> sum=0x00, cout=1, zero=1, ovf=0, after exactly 5 cycles; tag echoed.
- Signed overflow and carry-in, `WIDTH`=8:
  - 0x7F+0x01 -> sum=0x80, ovf=1, cout=0.
  - 0x10+0x0F with cin=1 -> sum=0x20.
- Subtract, `WIDTH`=8:
  - 0x05-0x07 -> sum=0xFE, cout=0, ovf=0.
  - 0x80-0x01 -> sum=0x7F, ovf=1, cout=1.
  - cin is ignored in both cases.
- Backpressure: stream 20 beats with `in_valid` held 1 and `out_ready`=0 for 12 cycles, then 1.
  - `in_ready` drops after 5 accepts.
  - All 20 results arrive in order with matching tags.
  - Held outputs do not change while stalled.
- Bubble/random: `WIDTH`=32 and 64, 10k random beats with random `in_valid`/`out_ready` toggling -> every result equals the reference model (A+Bx+c, flags) and ordering is preserved.
- Reset mid-flight: assert `rst` for 1 cycle with 4 beats in flight -> `out_valid`=0 and all outputs 0 immediately; the next accepted beat produces the correct result after `L` cycles.
